// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP
  } state_e;

  localparam int unsigned DMEM_WORDS = 65;

  localparam int unsigned PORT_MEM = 0;
  localparam int unsigned PORT_DBG = 1;

endpackage

// File: rtl/dmem_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick, registered last-winner pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] winner;
  logic          found;

  // Two passes: indices above the pointer first, then wrap to the rest.
  always_comb begin
    gnt_o  = '0;
    winner = ptr_q;
    found  = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && (j > 32'(ptr_q)) && req_i[PW'(j)]) begin
        found          = 1'b1;
        winner         = PW'(j);
        gnt_o[PW'(j)]  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && (j <= 32'(ptr_q)) && req_i[PW'(j)]) begin
        found          = 1'b1;
        winner         = PW'(j);
        gnt_o[PW'(j)]  = 1'b1;
      end
    end
  end

  assign valid_o = found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(NREQ - 1);
    end else if (en_i && found) begin
      ptr_q <= winner;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrated, sequenced single-port access to the async-read DataMemory array.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned MEM_WORDS     = DMEM_WORDS,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [32*NREQ-1:0]   addr,
  input  logic [32*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q, done_q, err_q;
  logic [31:0]     rdata_q, mem_addr_q, mem_wdata_q;
  logic            busy_q, mem_write_q, mem_read_q, we_q;
  logic [3:0]      cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_valid;
  logic            sel_we;
  logic [31:0]     sel_addr, sel_wdata;
  logic            sel_ok;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .en_i   (state_q == IDLE),
    .gnt_o  (arb_gnt),
    .valid_o(arb_valid)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (arb_gnt[j]) begin
        sel_we    = we[j];
        sel_addr  = addr[32*j +: 32];
        sel_wdata = wdata[32*j +: 32];
      end
    end
  end

  assign sel_ok = (sel_addr[1:0] == 2'b00) && (32'(sel_addr[31:2]) < MEM_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q  <= arb_gnt;
            we_q   <= sel_we;
            busy_q <= 1'b1;
            if (sel_ok) begin
              state_q     <= SETUP;
              mem_addr_q  <= {2'b00, sel_addr[31:2]};
              mem_wdata_q <= sel_wdata;
            end else begin
              // Rejected request: answer straight away, memory untouched.
              state_q <= RESP;
              done_q  <= arb_gnt;
              err_q   <= arb_gnt;
              rdata_q <= '0;
            end
          end
        end
        SETUP: begin
          state_q     <= STROBE;
          cnt_q       <= 4'(STROBE_CYCLES - 1);
          mem_write_q <= we_q;
          mem_read_q  <= ~we_q;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            done_q      <= gnt_q;
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural DataMemory model.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  localparam logic [31:0] POISON = 32'hBAD0_BAD0; // stands in for DataMemory X output

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic [1:0]  req, we, gnt, done, err;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, mem_write, mem_read;

  dmem_access_ctrl #(.NREQ(2), .MEM_WORDS(65), .STROBE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:64];
  always @(posedge clk) begin
    if (mem_write && mem_addr < 32'd65) mem[mem_addr[6:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_read && mem_addr < 32'd65) ? mem[mem_addr[6:0]] : POISON;

  // DUT B: three-cycle strobe
  logic [1:0]  b_req, b_we, b_gnt, b_done, b_err;
  logic [63:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_busy, b_mem_write, b_mem_read;

  dmem_access_ctrl #(.NREQ(2), .MEM_WORDS(65), .STROBE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .gnt(b_gnt), .done(b_done), .err(b_err), .rdata(b_rdata), .busy(b_busy),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );
  assign b_mem_rdata = b_mem_read ? ((b_mem_addr == 32'd64) ? 32'h1E : b_mem_addr) : POISON;

  int errors = 0;
  int checks = 0;
  int n_rd, n_wr, both_hi, gnt_bad;
  logic [31:0] st_addr, st_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Steps negedges until done on DUT A (max 20), recording strobe activity.
  task automatic wait_done(output int cyc, output logic [1:0] d);
    cyc = 0;
    d = 2'b00;
    n_rd = 0;
    n_wr = 0;
    st_addr = '0;
    st_wdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (mem_read && mem_write) both_hi++;
      if (!$onehot0(gnt)) gnt_bad++;
      if (mem_read || mem_write) begin
        st_addr = mem_addr;
        st_wdata = mem_wdata;
      end
      if (done != 2'b00) begin
        cyc = k;
        d = done;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  done;
    logic        err;
    int          cyc;
    logic [31:0] rdata;
    int          rd, wr;
    logic [31:0] maddr;
  } vec_t;

  vec_t vt [11];

  initial begin
    int cyc;
    logic [1:0] d;
    logic [31:0] exp_wd;

    for (int i = 0; i < 65; i++) mem[i] = 32'h1000 + 32'(i);
    mem[64] = 32'h0000_001E;
    both_hi = 0;
    gnt_bad = 0;

    //        req    we     a0          a1          d0            d1            done   err  cyc rdata         rd wr maddr
    vt[0]  = '{2'b01, 2'b00, 32'h100,    32'h0,      32'h0,        32'h0,        2'b01, 1'b0, 3, 32'h1E,       1, 0, 32'd64};
    vt[1]  = '{2'b10, 2'b10, 32'h0,      32'h10,     32'h0,        32'hDEADBEEF, 2'b10, 1'b0, 3, 32'h1E,       0, 1, 32'd4};
    vt[2]  = '{2'b10, 2'b00, 32'h0,      32'h10,     32'h0,        32'h0,        2'b10, 1'b0, 3, 32'hDEADBEEF, 1, 0, 32'd4};
    vt[3]  = '{2'b01, 2'b00, 32'h3,      32'h0,      32'h0,        32'h0,        2'b01, 1'b1, 1, 32'h0,        0, 0, 32'd0};
    vt[4]  = '{2'b01, 2'b00, 32'h104,    32'h0,      32'h0,        32'h0,        2'b01, 1'b1, 1, 32'h0,        0, 0, 32'd0};
    vt[5]  = '{2'b10, 2'b10, 32'h0,      32'h12,     32'h0,        32'h1,        2'b10, 1'b1, 1, 32'h0,        0, 0, 32'd0};
    vt[6]  = '{2'b01, 2'b01, 32'h0,      32'h0,      32'h55AA,     32'h0,        2'b01, 1'b0, 3, 32'h0,        0, 1, 32'd0};
    vt[7]  = '{2'b01, 2'b00, 32'h0,      32'h0,      32'h0,        32'h0,        2'b01, 1'b0, 3, 32'h55AA,     1, 0, 32'd0};
    vt[8]  = '{2'b11, 2'b00, 32'h10,     32'h100,    32'h0,        32'h0,        2'b10, 1'b0, 3, 32'h1E,       1, 0, 32'd64};
    vt[9]  = '{2'b10, 2'b10, 32'h0,      32'h100,    32'h0,        32'h12345678, 2'b10, 1'b0, 3, 32'h1E,       0, 1, 32'd64};
    vt[10] = '{2'b01, 2'b00, 32'h100,    32'h0,      32'hCAFE0000, 32'h0,        2'b01, 1'b0, 3, 32'h12345678, 1, 0, 32'd64};

    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {23'd0, gnt, done, err, busy, mem_write, mem_read}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_maddr", mem_addr, 32'd0);
    check("reset_b_ctrl", {23'd0, b_gnt, b_done, b_err, b_busy, b_mem_write, b_mem_read}, 32'd0);
    rst_n = 1'b1;

    // Continuous contention from reset: port 0 first, then strict alternation.
    req = 2'b11; we = 2'b00;
    addr = {32'h8, 32'h100};
    for (int t = 0; t < 4; t++) begin
      wait_done(cyc, d);
      check($sformatf("cont%0d_cyc", t), cyc, 3);
      check($sformatf("cont%0d_owner", t), {30'd0, d}, (t % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("cont%0d_rdata", t), rdata, (t % 2 == 0) ? 32'h1E : 32'h1002);
      if (t == 3) req = 2'b00;
      @(negedge clk);
      check($sformatf("cont%0d_pulse", t), {30'd0, done}, 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      req = vt[i].req; we = vt[i].we;
      addr = {vt[i].a1, vt[i].a0};
      wdata = {vt[i].d1, vt[i].d0};
      wait_done(cyc, d);
      req = 2'b00;
      check($sformatf("v%0d_cyc", i), cyc, vt[i].cyc);
      check($sformatf("v%0d_done", i), {30'd0, d}, {30'd0, vt[i].done});
      check($sformatf("v%0d_err", i), {30'd0, err}, vt[i].err ? {30'd0, vt[i].done} : 32'd0);
      check($sformatf("v%0d_gnt", i), {30'd0, gnt}, {30'd0, vt[i].done});
      check($sformatf("v%0d_rdata", i), rdata, vt[i].rdata);
      check($sformatf("v%0d_rd", i), n_rd, vt[i].rd);
      check($sformatf("v%0d_wr", i), n_wr, vt[i].wr);
      if (vt[i].rd + vt[i].wr > 0) check($sformatf("v%0d_maddr", i), st_addr, vt[i].maddr);
      if (vt[i].wr > 0) begin
        exp_wd = vt[i].done[PORT_DBG] ? vt[i].d1 : vt[i].d0;
        check($sformatf("v%0d_wdata", i), st_wdata, exp_wd);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle", i), {27'd0, done, gnt, busy}, 32'd0);
    end

    // Three-cycle strobe on the second instance.
    b_req = 2'b01; b_we = 2'b00; b_addr = {32'h0, 32'h100};
    cyc = 0; n_rd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b_mem_read) n_rd++;
      if (b_mem_read && b_mem_write) both_hi++;
      if (b_done != 2'b00) begin
        cyc = k;
        break;
      end
    end
    b_req = 2'b00;
    check("s3_cyc", cyc, 5);
    check("s3_rd", n_rd, 3);
    check("s3_rdata", b_rdata, 32'h1E);
    check("s3_err", {30'd0, b_err}, 32'd0);

    // Reset during STROBE, then port 0 must win the first grant afterwards.
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h10}; wdata = {32'h0, 32'hCAFE0000};
    repeat (2) @(negedge clk);
    check("rst_pre_strobe", {31'd0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {23'd0, gnt, done, err, busy, mem_write, mem_read}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_maddr", mem_addr, 32'd0);
    check("rst_mid_mwdata", mem_wdata, 32'd0);
    req = 2'b11; addr = {32'h100, 32'h10};
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(cyc, d);
    req = 2'b00;
    check("rst_post_cyc", cyc, 3);
    check("rst_post_owner", {30'd0, d}, 32'd1);
    check("rst_post_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);

    check("never_both_strobes", both_hi, 0);
    check("gnt_onehot", gnt_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
